// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath sequencer: FSM states, IR field
// positions, opcode/op values, mux and ALU encodings, and the per-state control word.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    localparam int IR_OPC_MSB = 15;
    localparam int IR_OPC_LSB = 13;
    localparam int IR_OP_MSB  = 12;
    localparam int IR_OP_LSB  = 11;
    localparam int IR_RN_MSB  = 10;
    localparam int IR_RN_LSB  = 8;
    localparam int IR_RD_MSB  = 7;
    localparam int IR_RD_LSB  = 5;
    localparam int IR_SH_MSB  = 4;
    localparam int IR_SH_LSB  = 3;
    localparam int IR_RM_MSB  = 2;
    localparam int IR_RM_LSB  = 0;
    localparam int IR_IMM_MSB = 7;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b01;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] vsel;
        logic [1:0] aluop;
    } ctrl_t;

    // Control word that must be visible while the FSM sits in state st.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] rn,
                                       input logic [2:0] rd, input logic [2:0] rm,
                                       input logic [1:0] op, input logic one_src,
                                       input logic mov_reg, input logic cmp);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT: c.w = 1'b1;
            S_WRITE_IMM: begin
                c.writenum = rn;
                c.vsel     = VSEL_IMM8;
                c.write    = 1'b1;
            end
            S_GET_A: begin
                c.readnum = rn;
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = rm;
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                c.loadc = 1'b1;
                c.asel  = one_src;
                c.aluop = mov_reg ? ALU_ADD : op;
                c.loads = cmp;
            end
            S_WRITE_REG: begin
                c.writenum = rd;
                c.vsel     = VSEL_C;
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction decode: IR field split, imm8 sign extension and
// instruction class flags used by the sequencer.
module instr_dec
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op,
    output logic [15:0] sximm8,
    output logic        legal,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_one_src,
    output logic        is_cmp
);

    logic [2:0] opc;
    logic       is_alu;

    assign opc    = ir[IR_OPC_MSB:IR_OPC_LSB];
    assign op     = ir[IR_OP_MSB:IR_OP_LSB];
    assign rn     = ir[IR_RN_MSB:IR_RN_LSB];
    assign rd     = ir[IR_RD_MSB:IR_RD_LSB];
    assign sh     = ir[IR_SH_MSB:IR_SH_LSB];
    assign rm     = ir[IR_RM_MSB:IR_RM_LSB];
    assign sximm8 = {{8{ir[IR_IMM_MSB]}}, ir[IR_IMM_MSB:0]};

    assign is_alu     = (opc == OPC_ALU);
    assign is_mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
    assign is_cmp     = is_alu && (op == OP_CMP);
    // MOV reg and MVN only need the B operand; A is forced to zero.
    assign is_one_src = is_mov_reg || (is_alu && (op == OP_MVN));
    assign legal      = is_alu || is_mov_imm || is_mov_reg;

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer: holds the IR and steps the register file, pipeline
// registers, ALU and status register through one instruction per start pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_WAIT      | idle, w=1; load latches IR, s starts execution
// S_DECODE    | classify IR and pick the operand path
// S_WRITE_IMM | write sximm8 into Rn
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_EXEC      | ALU result into C; CMP also loads status and finishes
// S_WRITE_REG | write C into Rd
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8
);

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    ctrl_t       ctrl;
    ctrl_t       ctrl_idle;

    logic [2:0] rn, rd, rm;
    logic [1:0] op;
    logic       legal, is_mov_imm, is_mov_reg, is_one_src, is_cmp;

    instr_dec u_dec (
        .ir         (ir),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (shift),
        .op         (op),
        .sximm8     (sximm8),
        .legal      (legal),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_one_src (is_one_src),
        .is_cmp     (is_cmp)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:      if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (!legal)          state_next = S_WAIT;
                else if (is_mov_imm) state_next = S_WRITE_IMM;
                else if (is_one_src) state_next = S_GET_B;
                else                 state_next = S_GET_A;
            end
            S_WRITE_IMM: state_next = S_WAIT;
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_EXEC;
            S_EXEC:      state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    assign ctrl_idle = ctrl_for(S_WAIT, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
            ctrl  <= ctrl_idle;
        end else begin
            state <= state_next;
            if (state == S_WAIT && load)
                ir <= in;
            ctrl <= ctrl_for(state_next, rn, rd, rm, op, is_one_src, is_mov_reg, is_cmp);
        end
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign vsel     = ctrl.vsel;
    assign aluop    = ctrl.aluop;
    assign bsel     = 1'b0;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: a per-cycle expected output trace is built
// from the instruction word when it is started, then popped and compared each cycle.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;

    datapath_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
        .aluop(aluop), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] outs;
        logic [15:0] ir;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [35:0] outs_obs;
    assign outs_obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                       asel, bsel, vsel, shift, aluop, sximm8};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] pack(input logic w_, input logic [2:0] rdn,
                                         input logic [2:0] wrn, input logic wr,
                                         input logic la, input logic lb, input logic lc,
                                         input logic ls, input logic as, input logic [1:0] vs,
                                         input logic [1:0] alu, input logic [15:0] wd);
        return {w_, rdn, wrn, wr, la, lb, lc, ls, as, 1'b0, vs, wd[4:3], alu,
                {{8{wd[7]}}, wd[7:0]}};
    endfunction

    task automatic push(input logic [35:0] o, input logic [15:0] ir_exp);
        exp_t e;
        e.outs = o;
        e.ir   = ir_exp;
        sb.push_back(e);
    endtask

    // Expected trace for one instruction: DECODE through the returning WAIT cycle.
    task automatic plan(input logic [15:0] wd);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        opc = wd[15:13]; op = wd[12:11];
        rn  = wd[10:8];  rd = wd[7:5]; rm = wd[2:0];
        push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, wd), wd);
        if (opc == 3'b110 && op == 2'b10) begin
            push(pack(0, 0, rn, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, wd), wd);
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            push(pack(0, rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, wd), wd);
            push(pack(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, (opc == 3'b110) ? 2'b00 : 2'b11, wd), wd);
            push(pack(0, 0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, wd), wd);
        end else if (opc == 3'b101) begin
            push(pack(0, rn, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, wd), wd);
            push(pack(0, rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, wd), wd);
            push(pack(0, 0, 0, 0, 0, 0, 1, (op == 2'b01), 0, 2'b00, op, wd), wd);
            if (op != 2'b01)
                push(pack(0, 0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, wd), wd);
        end
        push(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, wd), wd);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_c%0d no expected entry queued", tag, cyc);
        end else begin
            e = sb.pop_front();
            check_val($sformatf("%s_c%0d_outs", tag, cyc), {28'd0, outs_obs}, {28'd0, e.outs});
            check_val($sformatf("%s_c%0d_ir", tag, cyc), {48'd0, dut.ir}, {48'd0, e.ir});
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) step(tag);
    endtask

    task automatic start(input logic [15:0] wd);
        @(negedge clk);
        in   = wd;
        load = 1'b1;
        s    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        s    = 1'b0;
        cyc  = 0;
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) push(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000), 16'h0000);
        drain("idle");

        start(16'hD3FB); plan(16'hD3FB); drain("movimm");
        start(16'hA148); plan(16'hA148); drain("add");
        start(16'hAD06); plan(16'hAD06); drain("cmp");
        start(16'hE000); plan(16'hE000); drain("illegal111");
        start(16'hC800); plan(16'hC800); drain("illegal110_01");
        start(16'hC071); plan(16'hC071); drain("movreg");
        start(16'hB887); plan(16'hB887); drain("mvn");

        // A load pulse mid-operation must not disturb IR.
        start(16'hB23B); plan(16'hB23B);
        step("and_load");
        load = 1'b1;
        in   = 16'hFFFF;
        drain("and_load");
        load = 1'b0;

        // Reset while in GET_B returns to WAIT with IR cleared and no write.
        start(16'hA148); plan(16'hA148);
        repeat (3) step("add_rst");
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) push(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'h0000), 16'h0000);
        drain("add_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
